imem_fetch_unit: RTL

//  Parametrised instruction memory plus fetch front-end for the five-stage pipeline CPU.
//  - Accepts PC requests with a valid/ready handshake.
//  - Reads one 32-bit little-endian instruction per request.
//  - Buffers results in a response FIFO so IF/ID back-pressure never drops an instruction.
//  - Supports a branch/jump flush, flags misaligned and out-of-range fetches, and emits
//    pre-split RV32 fields to the decoder.

---
 rtl/imem_fetch_unit_pkg.sv | 37 +++
 rtl/imem_fetch_unit_resp_fifo.sv | 73 +++++++
 rtl/imem_fetch_unit.sv | 112 +++++++++++
 3 files changed

// File: rtl/imem_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch front-end.
//   NOP          canonical RV32 no-op (addi x0, x0, 0)
//   fault_e      fault codes carried with every fetched entry
//   *_LSB/*_W    RV32 field bit positions used for the pre-split decoder outputs
//   fault_of()   fault classification with misaligned taking priority over range
package imem_fetch_unit_pkg;

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    FLT_OK    = 2'b00,
    FLT_MIS   = 2'b01,
    FLT_RANGE = 2'b10
  } fault_e;

  localparam int unsigned OP_LSB     = 0;
  localparam int unsigned OP_W       = 7;
  localparam int unsigned RD_LSB     = 7;
  localparam int unsigned RD_W       = 5;
  localparam int unsigned FUNCT3_LSB = 12;
  localparam int unsigned FUNCT3_W   = 3;
  localparam int unsigned RS1_LSB    = 15;
  localparam int unsigned RS1_W      = 5;
  localparam int unsigned RS2_LSB    = 20;
  localparam int unsigned RS2_W      = 5;
  localparam int unsigned FUNCT7_LSB = 25;
  localparam int unsigned FUNCT7_W   = 7;
  localparam int unsigned IMM_LSB    = 7;
  localparam int unsigned IMM_W      = 25;

  function automatic fault_e fault_of(input logic misaligned, input logic out_of_range);
    if (misaligned)        return FLT_MIS;
    else if (out_of_range) return FLT_RANGE;
    else                   return FLT_OK;
  endfunction

endpackage

// File: rtl/imem_fetch_unit_resp_fifo.sv
// imem_resp_fifo: synchronous response FIFO for the fetch unit.
//   CLK          clock
//   Reset        asynchronous active-low reset
//   flush_i      synchronous clear of all entries (overrides push and pop)
//   push_i       write push_data_i (accepted when not full, or full with a pop)
//   push_data_i  entry to write
//   pop_i        remove head (ignored when empty)
//   count_o      current occupancy
//   head_o       oldest entry (meaningful only when count_o != 0)
module imem_resp_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 3,
  localparam int unsigned CW   = $clog2(DEPTH + 1)
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic [CW-1:0]    count_o,
  output logic [WIDTH-1:0] head_o
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    rd_q, wr_q;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             do_push, do_pop;

  // A push into a full FIFO is legal only alongside a pop; the write lands in
  // the slot being vacated, which is read out before the edge overwrites it.
  assign do_pop  = pop_i && (cnt_q != '0);
  assign do_push = push_i && ((cnt_q != CW'(DEPTH)) || do_pop);

  function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    cnt_d = cnt_q;
    unique case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else if (flush_i) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= bump(wr_q);
      if (do_pop)  rd_q <= bump(rd_q);
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (do_push && !flush_i) mem_q[wr_q] <= push_data_i;
  end

  assign count_o = cnt_q;
  assign head_o  = mem_q[rd_q];

endmodule

// File: rtl/imem_fetch_unit.sv
// imem_fetch_unit: read-only instruction memory plus fetch front-end.
//   CLK, Reset         clock, asynchronous active-low reset
//   flush              kill in-flight and buffered fetches
//   req_valid/req_pc   fetch request (byte address), accepted on req_valid & req_ready
//   req_ready          room for one more outstanding fetch
//   rsp_valid/ready    head handshake towards IF/ID
//   rsp_pc/instr/fault head entry; pc 0, NOP, ok when no entry is present
//   op..funct7, imm    RV32 fields split from rsp_instr
// The ROM image is supplied as a packed parameter, word i at INIT_IMAGE[32*i +: 32].
module imem_fetch_unit
  import imem_fetch_unit_pkg::*;
#(
  parameter int unsigned        PC_W       = 32,
  parameter int unsigned        DEPTH      = 64,
  parameter int unsigned        FIFO_DEPTH = 3,
  parameter logic [DEPTH*32-1:0] INIT_IMAGE = {DEPTH{NOP}}
) (
  input  logic            CLK,
  input  logic            Reset,
  input  logic            flush,
  input  logic            req_valid,
  input  logic [PC_W-1:0] req_pc,
  output logic            req_ready,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [PC_W-1:0] rsp_pc,
  output logic [31:0]     rsp_instr,
  output logic [1:0]      rsp_fault,
  output logic [6:0]      op,
  output logic [4:0]      rd,
  output logic [2:0]      funct3,
  output logic [4:0]      rs1,
  output logic [4:0]      rs2,
  output logic [6:0]      funct7,
  output logic [24:0]     imm
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned EW = PC_W + 32 + 2;

  logic [AW-1:0]   word_idx;
  fault_e          req_fault;
  logic [31:0]     req_instr;
  logic            fire;

  logic            if_valid_q;
  logic [PC_W-1:0] if_pc_q;
  logic [31:0]     if_instr_q;
  logic [1:0]      if_fault_q;

  logic [CW-1:0]   occ;
  logic [EW-1:0]   head;
  logic [PC_W-1:0] head_pc;
  logic [31:0]     head_instr;
  logic [1:0]      head_fault;

  assign word_idx  = req_pc[AW+1:2];
  assign req_fault = fault_of(req_pc[1:0] != 2'b00, (req_pc >> 2) >= PC_W'(DEPTH));
  assign req_instr = (req_fault == FLT_OK) ? INIT_IMAGE[{word_idx, 5'd0} +: 32] : NOP;

  // Capacity counts the in-flight slot so a fetch always has a FIFO entry
  // waiting for it; depends only on registered state, never on rsp_ready.
  assign req_ready = Reset && !flush && ((32'(occ) + 32'(if_valid_q)) < FIFO_DEPTH);
  assign fire      = req_valid && req_ready;

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      if_valid_q <= 1'b0;
      if_pc_q    <= '0;
      if_instr_q <= NOP;
      if_fault_q <= FLT_OK;
    end else begin
      if_valid_q <= fire;
      if (fire) begin
        if_pc_q    <= req_pc;
        if_instr_q <= req_instr;
        if_fault_q <= req_fault;
      end
    end
  end

  imem_resp_fifo #(
    .WIDTH (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .CLK         (CLK),
    .Reset       (Reset),
    .flush_i     (flush),
    .push_i      (if_valid_q),
    .push_data_i ({if_pc_q, if_instr_q, if_fault_q}),
    .pop_i       (rsp_ready),
    .count_o     (occ),
    .head_o      (head)
  );

  assign {head_pc, head_instr, head_fault} = head;

  assign rsp_valid = (occ != '0);
  assign rsp_pc    = rsp_valid ? head_pc    : '0;
  assign rsp_instr = rsp_valid ? head_instr : NOP;
  assign rsp_fault = rsp_valid ? head_fault : FLT_OK;

  assign op     = rsp_instr[OP_LSB     +: OP_W];
  assign rd     = rsp_instr[RD_LSB     +: RD_W];
  assign funct3 = rsp_instr[FUNCT3_LSB +: FUNCT3_W];
  assign rs1    = rsp_instr[RS1_LSB    +: RS1_W];
  assign rs2    = rsp_instr[RS2_LSB    +: RS2_W];
  assign funct7 = rsp_instr[FUNCT7_LSB +: FUNCT7_W];
  assign imm    = rsp_instr[IMM_LSB    +: IMM_W];

endmodule
